// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

   localparam int FB_WIDTH_DEF  = 400;
   localparam int FB_HEIGHT_DEF = 240;
   localparam int OPAQUE_BIT    = 0;

   typedef logic [15:0] color_t;

   typedef enum logic {
      S_IDLE,
      S_PENDING
   } swap_state_t;

   function automatic int addr_width(input int w, input int h);
      return $clog2(w * h);
   endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: synchronous write port, registered read port.
module fb_bank
   import fb_pkg::*;
#(
   parameter int DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
   parameter int AW    = addr_width(FB_WIDTH_DEF, FB_HEIGHT_DEF)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  color_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output color_t        rdata
);

   color_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store; swaps commit only on a vblank rising edge.
module frame_buffer
   import fb_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [$clog2(FB_WIDTH):0]    wr_x,
   input  logic [$clog2(FB_HEIGHT):0]   wr_y,
   input  color_t                       wr_color,
   input  logic                         wr_write,
   input  logic [$clog2(FB_WIDTH):0]    rd_x,
   input  logic [$clog2(FB_HEIGHT):0]   rd_y,
   input  logic                         rd_read,
   output color_t                       rd_color,
   output logic                         rd_valid,
   input  logic                         swap_req,
   input  logic                         vblank,
   output logic                         swap_pending,
   output logic                         swap_done,
   output logic                         front_sel
);

   localparam int XW    = $clog2(FB_WIDTH) + 1;
   localparam int YW    = $clog2(FB_HEIGHT) + 1;
   localparam int AW    = addr_width(FB_WIDTH, FB_HEIGHT);
   localparam int DEPTH = FB_WIDTH * FB_HEIGHT;

   localparam logic [XW-1:0] X_LIM = XW'(FB_WIDTH);
   localparam logic [YW-1:0] Y_LIM = YW'(FB_HEIGHT);
   localparam logic [AW-1:0] W_A   = AW'(FB_WIDTH);

   swap_state_t   state;
   logic          req_q, vb_q;
   logic          req_edge, vb_edge;
   logic          wr_ok, rd_ok;
   logic [AW-1:0] waddr, raddr;
   logic          rd_ok_q, rd_sel_q;
   color_t        dout0, dout1;

   // Coordinates are bounds-checked first, so the product stays in range.
   assign wr_ok = wr_write && (wr_x < X_LIM) && (wr_y < Y_LIM);
   assign rd_ok = rd_read && (rd_x < X_LIM) && (rd_y < Y_LIM);
   assign waddr = AW'(wr_y) * W_A + AW'(wr_x);
   assign raddr = AW'(rd_y) * W_A + AW'(rd_x);

   fb_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
      .clk   (clk),
      .we    (wr_ok && front_sel),
      .waddr (waddr),
      .wdata (wr_color),
      .re    (rd_ok && !front_sel),
      .raddr (raddr),
      .rdata (dout0)
   );

   fb_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
      .clk   (clk),
      .we    (wr_ok && !front_sel),
      .waddr (waddr),
      .wdata (wr_color),
      .re    (rd_ok && front_sel),
      .raddr (raddr),
      .rdata (dout1)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_ok_q  <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         rd_valid <= rd_read;
         rd_ok_q  <= rd_ok;
         rd_sel_q <= front_sel;
      end
   end

   assign rd_color = !rd_ok_q ? '0 : (rd_sel_q ? dout1 : dout0);

   // Zero-reset history makes a level already high at release look like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_q <= 1'b0;
         vb_q  <= 1'b0;
      end else begin
         req_q <= swap_req;
         vb_q  <= vblank;
      end
   end

   assign req_edge = swap_req && !req_q;
   assign vb_edge  = vblank && !vb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
      end else begin
         swap_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_edge && vb_edge) begin
                  front_sel <= !front_sel;
                  swap_done <= 1'b1;
               end else if (req_edge) begin
                  state        <= S_PENDING;
                  swap_pending <= 1'b1;
               end
            end
            S_PENDING: begin
               if (vb_edge) begin
                  front_sel    <= !front_sel;
                  swap_done    <= 1'b1;
                  swap_pending <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
